// File: rtl/bcd_up_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_up_down_counter
//
// Two-digit packed-BCD up/down counter over 00..MAX_VAL with a parallel load.
// It is driven by board push-buttons and feeds the BCD-to-binary converter,
// so the count is always a legal code (units 0..9, tens 0..9, value <= MAX_VAL).
//
// Parameters
//   MAX_VAL      highest count in decimal, 1..99 (19 keeps the downstream
//                5-bit range honoured)
//   SYNC_STAGES  depth of the input synchronizer chains, >= 2
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   RST       in   synchronous reset, active-high
//   KEY_UP    in   asynchronous increment button, active-high
//   KEY_DN    in   asynchronous decrement button, active-high
//   LOAD      in   asynchronous load request, active-high level
//   LOAD_VAL  in   packed BCD load value [7:4] tens, [3:0] units; sampled
//                  directly on the cycle the synchronized LOAD edge is acted on
//   BCD       out  current count, packed BCD
//   WRAP      out  one-cycle pulse on wrap-around in either direction
//   LOAD_ERR  out  one-cycle pulse when a load value is rejected
// -----------------------------------------------------------------------------
module bcd_up_down_counter #(
   parameter int MAX_VAL     = 19,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLOCK_50,
   input  logic       RST,
   input  logic       KEY_UP,
   input  logic       KEY_DN,
   input  logic       LOAD,
   input  logic [7:0] LOAD_VAL,
   output logic [7:0] BCD,
   output logic       WRAP,
   output logic       LOAD_ERR
);

   localparam logic [7:0] MAX_BIN = 8'(MAX_VAL);
   localparam logic [7:0] MAX_BCD = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};

   // Synchronizer chains; bit 0 is the metastability-exposed stage.
   logic [SYNC_STAGES-1:0] up_sync;
   logic [SYNC_STAGES-1:0] dn_sync;
   logic [SYNC_STAGES-1:0] ld_sync;

   // Previous-cycle value of each chain's last stage, for rising-edge detect.
   logic up_prev;
   logic dn_prev;
   logic ld_prev;

   logic up_evt;
   logic dn_evt;
   logic ld_evt;

   // Digit-wise BCD increment; the caller handles the MAX_VAL wrap, so
   // units 9 always carries into a tens digit that stays legal.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Digit-wise BCD decrement; the caller handles 00 -> MAX_VAL.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // A load is accepted only if both digits are decimal and the value fits.
   // Worst case 15*10+15 = 165 still fits in 8 bits.
   function automatic logic load_legal(input logic [7:0] v);
      logic [7:0] bin;
      bin = 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (bin <= MAX_BIN);
   endfunction

   // ---- stage boundary: synchronized inputs -> single-cycle events ----
   assign up_evt = up_sync[SYNC_STAGES-1] & ~up_prev;
   assign dn_evt = dn_sync[SYNC_STAGES-1] & ~dn_prev;
   assign ld_evt = ld_sync[SYNC_STAGES-1] & ~ld_prev;

   // ---- stage boundary: events -> registered count and pulses ----
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         up_sync  <= '0;
         dn_sync  <= '0;
         ld_sync  <= '0;
         up_prev  <= 1'b0;
         dn_prev  <= 1'b0;
         ld_prev  <= 1'b0;
         BCD      <= 8'h00;
         WRAP     <= 1'b0;
         LOAD_ERR <= 1'b0;
      end else begin
         up_sync  <= {up_sync[SYNC_STAGES-2:0], KEY_UP};
         dn_sync  <= {dn_sync[SYNC_STAGES-2:0], KEY_DN};
         ld_sync  <= {ld_sync[SYNC_STAGES-2:0], LOAD};
         up_prev  <= up_sync[SYNC_STAGES-1];
         dn_prev  <= dn_sync[SYNC_STAGES-1];
         ld_prev  <= ld_sync[SYNC_STAGES-1];
         WRAP     <= 1'b0;
         LOAD_ERR <= 1'b0;

         // Load beats the keys; simultaneous up and down cancel out.
         if (ld_evt) begin
            if (load_legal(LOAD_VAL))
               BCD <= LOAD_VAL;
            else
               LOAD_ERR <= 1'b1;
         end else if (up_evt && dn_evt) begin
            BCD <= BCD;
         end else if (up_evt) begin
            if (BCD == MAX_BCD) begin
               BCD  <= 8'h00;
               WRAP <= 1'b1;
            end else begin
               BCD <= bcd_inc(BCD);
            end
         end else if (dn_evt) begin
            if (BCD == 8'h00) begin
               BCD  <= MAX_BCD;
               WRAP <= 1'b1;
            end else begin
               BCD <= bcd_dec(BCD);
            end
         end
      end
   end

endmodule
